// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared definitions for the common data bus arbiter: default field widths,
// the FU id encoding driven onto cdb_fu_id, and small helpers for the
// three-way round-robin search.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int NUM_FU     = 3;
  localparam int TAG_W_DEF  = 6;
  localparam int ROB_W_DEF  = 6;
  localparam int DATA_W_DEF = 32;

  // FU id encoding shared with the reservation station.
  typedef enum logic [1:0] {
    FU1_ID = 2'd0,
    FU2_ID = 2'd1,
    FU3_ID = 2'd2
  } fu_id_e;

  // Slot visited at search offset 'off' when the search starts at 'ptr'.
  // 'ptr' is always 0..2, so one conditional subtract gives the modulo-3 result.
  function automatic logic [1:0] rr_slot(input logic [1:0] ptr, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, ptr} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Encode a one-hot grant as an FU id; an empty grant maps to FU1_ID.
  function automatic fu_id_e grant_to_id(input logic [2:0] grant);
    fu_id_e id;
    id = FU1_ID;
    if (grant[1]) id = FU2_ID;
    if (grant[2]) id = FU3_ID;
    return id;
  endfunction

  // Pointer value after a grant: the slot just past the winner, wrapping 2 -> 0.
  function automatic logic [1:0] ptr_after(input logic [2:0] grant);
    fu_id_e id;
    id = grant_to_id(grant);
    return (id == FU3_ID) ? 2'd0 : 2'(id) + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Three-requester round-robin arbiter with its own rotating pointer.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high; pointer returns to slot 0
//   en     in   arbitration enable; no grant and pointer hold when low
//   req    in   [2:0] request per slot
//   grant  out  [2:0] one-hot grant (combinational)
// -----------------------------------------------------------------------------
module rr_arbiter3
  import cdb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] req,
  output logic [2:0] grant
);

  logic [1:0] r_ptr;

  // Search begins at r_ptr; the first requesting slot wins.
  always_comb begin
    logic       w_found;
    logic [1:0] w_idx;
    grant   = 3'b000;
    w_found = 1'b0;
    w_idx   = 2'd0;
    if (en) begin
      for (int off = 0; off < NUM_FU; off++) begin
        w_idx = rr_slot(r_ptr, 2'(off));
        if (!w_found && req[w_idx]) begin
          grant[w_idx] = 1'b1;
          w_found      = 1'b1;
        end
      end
    end
  end

  // Pointer only advances on an actual grant, so it never leaves 0..2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 2'd0;
    end else if (|grant) begin
      r_ptr <= ptr_after(grant);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the common data bus between three functional units. Each FU owns a
// one-entry result buffer; full buffers are granted round-robin and the winner
// is broadcast combinationally as {rd_tag, rob_num, value} to the RS and ROB.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   flush          mispredict flush; drops every buffered result
//   fu_valid[2:0]  FU(i+1) presents a result
//   fu_rd_tag      3 x TAG_W  destination tags, slice i = FU(i+1)
//   fu_rob_num     3 x ROB_W  ROB indices,     slice i = FU(i+1)
//   fu_value       3 x DATA_W results,         slice i = FU(i+1)
//   fu_ready[2:0]  buffer i accepts this cycle (combinational)
//   cdb_ready      ROB/RS can take a broadcast this cycle
//   cdb_valid      broadcast valid
//   cdb_rd_tag / cdb_rob_num / cdb_value  broadcast payload, zero when idle
//   cdb_fu_id      granted FU, 0..2 = FU1..FU3, zero when idle
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [2:0]            fu_valid,
  input  logic [3*TAG_W-1:0]    fu_rd_tag,
  input  logic [3*ROB_W-1:0]    fu_rob_num,
  input  logic [3*DATA_W-1:0]   fu_value,
  output logic [2:0]            fu_ready,
  input  logic                  cdb_ready,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_rd_tag,
  output logic [ROB_W-1:0]      cdb_rob_num,
  output logic [DATA_W-1:0]     cdb_value,
  output logic [1:0]            cdb_fu_id
);

  logic [2:0]        w_buf_v;
  logic [2:0]        w_grant;
  logic [2:0]        w_fu_ready;
  logic [TAG_W-1:0]  w_tag [NUM_FU];
  logic [ROB_W-1:0]  w_rob [NUM_FU];
  logic [DATA_W-1:0] w_val [NUM_FU];
  logic              w_arb_en;
  logic              w_bcast;

  // Flush and reset suppress the grant itself, so a pending winner is dropped
  // rather than broadcast and the pointer does not move.
  assign w_arb_en = cdb_ready & ~flush & ~reset;

  rr_arbiter3 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (w_arb_en),
    .req   (w_buf_v),
    .grant (w_grant)
  );

  generate
    for (genvar g = 0; g < NUM_FU; g++) begin : g_slice
      logic              r_v;
      logic [TAG_W-1:0]  r_tag;
      logic [ROB_W-1:0]  r_rob;
      logic [DATA_W-1:0] r_val;
      logic              w_xfer;

      // A buffer being granted this cycle frees up in time to take a new result.
      assign w_fu_ready[g] = ~reset & ~flush & (~r_v | w_grant[g]);
      assign w_xfer        = fu_valid[g] & w_fu_ready[g];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_v <= 1'b0;
        end else if (flush) begin
          r_v <= 1'b0;
        end else if (w_xfer) begin
          r_v <= 1'b1;
        end else if (w_grant[g]) begin
          r_v <= 1'b0;
        end
      end

      // Payload registers carry no reset; r_v qualifies them.
      always_ff @(posedge clk) begin
        if (w_xfer) begin
          r_tag <= fu_rd_tag[g*TAG_W +: TAG_W];
          r_rob <= fu_rob_num[g*ROB_W +: ROB_W];
          r_val <= fu_value[g*DATA_W +: DATA_W];
        end
      end

      assign w_buf_v[g] = r_v;
      assign w_tag[g]   = r_tag;
      assign w_rob[g]   = r_rob;
      assign w_val[g]   = r_val;
    end
  endgenerate

  assign fu_ready = w_fu_ready;
  assign w_bcast  = (|w_grant) & ~flush;

  // Output mux: payload is forced to zero whenever nothing is broadcast.
  always_comb begin
    cdb_valid   = w_bcast;
    cdb_rd_tag  = '0;
    cdb_rob_num = '0;
    cdb_value   = '0;
    cdb_fu_id   = 2'd0;
    if (w_bcast) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_grant[i]) begin
          cdb_rd_tag  = w_tag[i];
          cdb_rob_num = w_rob[i];
          cdb_value   = w_val[i];
        end
      end
      cdb_fu_id = 2'(grant_to_id(w_grant));
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int TAG_W  = 6;
  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;

  logic                clk;
  logic                reset;
  logic                flush;
  logic [2:0]          fu_valid;
  logic [3*TAG_W-1:0]  fu_rd_tag;
  logic [3*ROB_W-1:0]  fu_rob_num;
  logic [3*DATA_W-1:0] fu_value;
  logic [2:0]          fu_ready;
  logic                cdb_ready;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_rd_tag;
  logic [ROB_W-1:0]    cdb_rob_num;
  logic [DATA_W-1:0]   cdb_value;
  logic [1:0]          cdb_fu_id;

  int tests = 0;
  int fails = 0;

  cdb_arbiter #(.TAG_W(TAG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_rd_tag  (fu_rd_tag),
    .fu_rob_num (fu_rob_num),
    .fu_value   (fu_value),
    .fu_ready   (fu_ready),
    .cdb_ready  (cdb_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rd_tag (cdb_rd_tag),
    .cdb_rob_num(cdb_rob_num),
    .cdb_value  (cdb_value),
    .cdb_fu_id  (cdb_fu_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: three one-entry buffers and a rotating start index.
  bit          mv   [3];
  int unsigned mtag [3];
  int unsigned mrob [3];
  int unsigned mval [3];
  int          mptr;
  // Expectations for the current cycle.
  int          e_grant;
  logic [2:0]  e_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fu_set(input int i, input bit v, input int unsigned tag,
                        input int unsigned rob, input int unsigned val);
    fu_valid[i]                   = v;
    fu_rd_tag[i*TAG_W +: TAG_W]   = TAG_W'(tag);
    fu_rob_num[i*ROB_W +: ROB_W]  = ROB_W'(rob);
    fu_value[i*DATA_W +: DATA_W]  = DATA_W'(val);
  endtask

  // Let inputs settle mid-cycle, derive the expected outputs from the model,
  // and compare every output.
  task automatic settle();
    int k;
    #2;
    e_grant = -1;
    if (!reset && !flush && cdb_ready) begin
      for (int off = 0; off < 3; off++) begin
        k = (mptr + off) % 3;
        if (e_grant < 0 && mv[k]) e_grant = k;
      end
    end
    for (int i = 0; i < 3; i++)
      e_ready[i] = !reset && !flush && (!mv[i] || e_grant == i);
    check("fu_ready", 64'(fu_ready), 64'(e_ready));
    check("cdb_valid", 64'(cdb_valid), 64'(e_grant >= 0));
    check("cdb_rd_tag", 64'(cdb_rd_tag), (e_grant >= 0) ? 64'(TAG_W'(mtag[e_grant])) : 64'(0));
    check("cdb_rob_num", 64'(cdb_rob_num), (e_grant >= 0) ? 64'(ROB_W'(mrob[e_grant])) : 64'(0));
    check("cdb_value", 64'(cdb_value), (e_grant >= 0) ? 64'(mval[e_grant]) : 64'(0));
    check("cdb_fu_id", 64'(cdb_fu_id), (e_grant >= 0) ? 64'(e_grant) : 64'(0));
  endtask

  // Advance the model by the rules for one clock edge, then move past the edge.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 3; i++) mv[i] = 0;
      mptr = 0;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) mv[i] = 0;
    end else begin
      if (e_grant >= 0) begin
        mv[e_grant] = 0;
        mptr = (e_grant + 1) % 3;
      end
      for (int i = 0; i < 3; i++) begin
        if (fu_valid[i] && e_ready[i]) begin
          mv[i]   = 1;
          mtag[i] = fu_rd_tag[i*TAG_W +: TAG_W];
          mrob[i] = fu_rob_num[i*ROB_W +: ROB_W];
          mval[i] = fu_value[i*DATA_W +: DATA_W];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  bit          pend [3];
  int unsigned ptag [3];
  int unsigned prob [3];
  int unsigned pval [3];
  logic [2:0]  acc;

  initial begin
    for (int i = 0; i < 3; i++) begin mv[i] = 0; mtag[i] = 0; mrob[i] = 0; mval[i] = 0; end
    mptr = 0;
    reset = 1'b1; flush = 1'b0; cdb_ready = 1'b1;
    fu_valid = '0; fu_rd_tag = '0; fu_rob_num = '0; fu_value = '0;

    // Reset held for two cycles.
    repeat (2) begin
      settle();
      check("reset_fu_ready", 64'(fu_ready), 64'(3'b000));
      check("reset_cdb_valid", 64'(cdb_valid), 64'(0));
      tick();
    end

    // Release with FU1 presenting tag 1 / rob 1 / value 30.
    reset = 1'b0;
    fu_set(0, 1, 1, 1, 30);
    settle();
    check("release_fu_ready", 64'(fu_ready), 64'(3'b111));
    check("release_cdb_valid", 64'(cdb_valid), 64'(0));
    tick();
    fu_set(0, 0, 0, 0, 0);
    settle();
    check("single_valid", 64'(cdb_valid), 64'(1));
    check("single_tag", 64'(cdb_rd_tag), 64'(1));
    check("single_rob", 64'(cdb_rob_num), 64'(1));
    check("single_val", 64'(cdb_value), 64'(30));
    check("single_fu_id", 64'(cdb_fu_id), 64'(0));
    tick();
    settle();
    check("single_after_valid", 64'(cdb_valid), 64'(0));
    tick();

    // Round-robin from pointer 0 after a fresh reset.
    reset = 1'b1;
    settle(); tick();
    reset = 1'b0;
    fu_set(0, 1, 1, 1, 100); fu_set(1, 1, 4, 2, 200); fu_set(2, 1, 7, 3, 300);
    settle(); tick();
    fu_valid = '0;
    settle(); check("rr_first_tag", 64'(cdb_rd_tag), 64'(1)); tick();
    settle(); check("rr_second_tag", 64'(cdb_rd_tag), 64'(4)); tick();
    settle(); check("rr_third_tag", 64'(cdb_rd_tag), 64'(7)); check("rr_third_id", 64'(cdb_fu_id), 64'(2)); tick();

    // Backpressure with all buffers full; pointer should be back at FU1.
    cdb_ready = 1'b0;
    fu_set(0, 1, 2, 4, 11); fu_set(1, 1, 5, 5, 22); fu_set(2, 1, 8, 6, 33);
    settle(); check("bp_fill_ready", 64'(fu_ready), 64'(3'b111)); tick();
    fu_valid = '0;
    repeat (2) begin
      settle();
      check("bp_fu_ready", 64'(fu_ready), 64'(3'b000));
      check("bp_cdb_valid", 64'(cdb_valid), 64'(0));
      tick();
    end
    cdb_ready = 1'b1;
    settle(); check("bp_first_tag", 64'(cdb_rd_tag), 64'(2)); check("bp_first_id", 64'(cdb_fu_id), 64'(0)); tick();
    // Drain-and-refill: FU2 is granted while presenting tag 9.
    fu_set(1, 1, 9, 7, 44);
    settle();
    check("refill_tag", 64'(cdb_rd_tag), 64'(5));
    check("refill_ready1", 64'(fu_ready[1]), 64'(1));
    tick();
    fu_set(1, 0, 0, 0, 0);
    settle(); check("refill_fu3_tag", 64'(cdb_rd_tag), 64'(8)); tick();
    settle(); check("refill_new_tag", 64'(cdb_rd_tag), 64'(9)); check("refill_new_id", 64'(cdb_fu_id), 64'(1)); tick();

    // Flush with tags 1 and 4 buffered; pointer now at FU3.
    cdb_ready = 1'b0;
    fu_set(0, 1, 1, 8, 55); fu_set(1, 1, 4, 9, 66);
    settle(); tick();
    fu_valid = '0;
    flush = 1'b1; cdb_ready = 1'b1;
    settle();
    check("flush_cdb_valid", 64'(cdb_valid), 64'(0));
    check("flush_fu_ready", 64'(fu_ready), 64'(3'b000));
    tick();
    flush = 1'b0;
    settle();
    check("post_flush_valid", 64'(cdb_valid), 64'(0));
    check("post_flush_ready", 64'(fu_ready), 64'(3'b111));
    tick();
    cdb_ready = 1'b0;
    fu_set(0, 1, 11, 1, 1); fu_set(1, 1, 12, 2, 2); fu_set(2, 1, 13, 3, 3);
    settle(); tick();
    fu_valid = '0; cdb_ready = 1'b1;
    settle(); check("flush_ptr_kept_id", 64'(cdb_fu_id), 64'(2)); check("flush_ptr_kept_tag", 64'(cdb_rd_tag), 64'(13)); tick();

    // Randomised traffic: FUs hold each result until it is accepted.
    for (int i = 0; i < 3; i++) pend[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom % 200) == 0;
      flush     = !reset && (($urandom % 40) == 0);
      cdb_ready = ($urandom % 10) < 7;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom % 3) == 0) begin
          pend[i] = 1;
          ptag[i] = $urandom % 64;
          prob[i] = $urandom % 64;
          pval[i] = $urandom;
        end
        fu_set(i, pend[i], ptag[i], prob[i], pval[i]);
      end
      settle();
      acc = fu_valid & e_ready;
      tick();
      for (int i = 0; i < 3; i++) if (acc[i]) pend[i] = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
